// File: rtl/alsu_cmd_sequencer.sv
// ALSU command sequencer: FIFO-buffered valid/ready command intake,
// shift/rotate repeat issue, optional invalid drop, result-valid pipe.
module alsu_cmd_sequencer #(
  parameter int DEPTH        = 4,
  parameter bit DROP_INVALID = 1'b0,
  parameter int ALSU_LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_A,
  input  logic [2:0] cmd_B,
  input  logic [2:0] cmd_opcode,
  input  logic       cmd_cin,
  input  logic       cmd_serial_in,
  input  logic       cmd_red_op_A,
  input  logic       cmd_red_op_B,
  input  logic       cmd_bypass_A,
  input  logic       cmd_bypass_B,
  input  logic       cmd_direction,
  input  logic [2:0] cmd_repeat,
  output logic [2:0] A,
  output logic [2:0] B,
  output logic [2:0] opcode,
  output logic       cin,
  output logic       serial_in,
  output logic       red_op_A,
  output logic       red_op_B,
  output logic       bypass_A,
  output logic       bypass_B,
  output logic       direction,
  output logic       issue_valid,
  output logic       issue_last,
  output logic       result_valid,
  output logic       result_last,
  output logic [7:0] drop_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int L  = ALSU_LATENCY;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state_q, state_d;

  logic [18:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    rep_q, rep_d;
  logic [15:0]   bus_q, bus_d;
  logic          iv_q, iv_d;
  logic          il_q, il_d;
  logic [L-1:0]  rv_q, rl_q;
  logic [7:0]    drop_q;

  logic [18:0] cmd_w, head;
  logic [2:0]  hop;
  logic        full, empty, push, pop, drop;
  logic        head_inv, head_shift;

  assign cmd_w = {cmd_A, cmd_B, cmd_opcode, cmd_cin,
                  cmd_serial_in, cmd_red_op_A, cmd_red_op_B,
                  cmd_bypass_A, cmd_bypass_B, cmd_direction,
                  cmd_repeat};

  assign full      = (cnt_q == CW'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full && !flush;

  assign head       = mem_q[rd_q];
  assign hop        = head[12:10];
  assign head_inv   = (hop[2] & hop[1]) |
                      ((head[7] | head[6]) & (hop[2] | hop[1]));
  assign head_shift = hop[2] & ~hop[1];

  always_comb begin
    state_d = state_q;
    rep_d   = rep_q;
    bus_d   = '0;
    iv_d    = 1'b0;
    il_d    = 1'b0;
    pop     = 1'b0;
    drop    = 1'b0;
    if (state_q == RUN && rep_q != 3'd0) begin
      bus_d = bus_q;
      iv_d  = 1'b1;
      rep_d = rep_q - 3'd1;
      il_d  = (rep_q == 3'd1);
    end else if (!empty) begin
      pop = 1'b1;
      if (DROP_INVALID && head_inv) begin
        // a drop uses this cycle's only pop, so the bus idles
        drop    = 1'b1;
        rep_d   = 3'd0;
        state_d = IDLE;
      end else begin
        bus_d   = head[18:3];
        iv_d    = 1'b1;
        rep_d   = head_shift ? head[2:0] : 3'd0;
        il_d    = !(head_shift && head[2:0] != 3'd0);
        state_d = RUN;
      end
    end else begin
      rep_d   = 3'd0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= cmd_w;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      rep_q   <= '0;
      bus_q   <= '0;
      iv_q    <= 1'b0;
      il_q    <= 1'b0;
      rv_q    <= '0;
      rl_q    <= '0;
    end else if (flush) begin
      state_q <= IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      rep_q   <= '0;
      bus_q   <= '0;
      iv_q    <= 1'b0;
      il_q    <= 1'b0;
      rv_q    <= '0;
      rl_q    <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_q + AW'(push);
      rd_q    <= rd_q + AW'(pop);
      cnt_q   <= cnt_q + CW'(push) - CW'(pop);
      rep_q   <= rep_d;
      bus_q   <= bus_d;
      iv_q    <= iv_d;
      il_q    <= il_d;
      rv_q    <= (rv_q << 1) | L'(iv_q);
      rl_q    <= (rl_q << 1) | L'(il_q);
    end
  end

  // survives flush; only reset clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_q <= '0;
    else if (drop && !flush && drop_q != 8'hFF)
      drop_q <= drop_q + 8'd1;
  end

  assign {A, B, opcode, cin, serial_in, red_op_A, red_op_B,
          bypass_A, bypass_B, direction} = bus_q;
  assign issue_valid  = iv_q;
  assign issue_last   = il_q;
  assign result_valid = rv_q[L-1];
  assign result_last  = rl_q[L-1];
  assign drop_count   = drop_q;

endmodule

// File: doc/alsu_cmd_sequencer.md
Name: alsu_cmd_sequencer

Overview:
- Upstream feeder for the ALSU datapath.
- Accepts ALSU commands over a valid/ready handshake and buffers them in a small FIFO.
- Issues one command per cycle onto the ALSU input bus, repeating shift/rotate commands a programmed number of times.
- Optionally drops commands the ALSU would flag invalid.
- Produces a result-valid strobe aligned to the ALSU output register.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, 2..16).
- DROP_INVALID, 0, 1 = discard invalid commands at the head instead of issuing them.
- ALSU_LATENCY, 2, cycles from issue_valid to the matching ALSU out.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of FIFO and FSM
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO can accept; equals !full
- cmd_A  in  3  signed operand A
- cmd_B  in  3  signed operand B
- cmd_opcode  in  3  ALSU opcode
- cmd_cin  in  1  carry in
- cmd_serial_in  in  1  shift serial bit
- cmd_red_op_A  in  1  reduction on A
- cmd_red_op_B  in  1  reduction on B
- cmd_bypass_A  in  1  bypass A
- cmd_bypass_B  in  1  bypass B
- cmd_direction  in  1  shift/rotate direction
- cmd_repeat  in  3  extra issues for opcode 100/101; ignored otherwise
- A, B, opcode  out  3 each  registered ALSU inputs
- cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction  out  1 each  registered ALSU inputs
- issue_valid  out  1  ALSU bus carries a real command this cycle
- issue_last  out  1  final issue of the current command
- result_valid  out  1  ALSU out is valid for an issued command this cycle
- result_last  out  1  result_valid for a last issue
- drop_count  out  8  saturating count of dropped commands

Behaviour:
- Reset: FIFO empty, FSM IDLE, all outputs 0, cmd_ready=1 (the bus then equals the idle pattern).
- Idle pattern is all ALSU fields 0 (OR of 0,0 gives ALSU out 0).
- Push occurs when cmd_valid && cmd_ready. There is no bypass of a full FIFO: if the FIFO is full, cmd_ready=0 even when a pop happens in the same cycle.
- Invalid condition, evaluated on the FIFO head: (op[2]&op[1]) | ((red_op_A|red_op_B)&(op[2]|op[1])). Bypass does not override it.
- FSM state IDLE:
  - Head non-empty and valid: pop it, load the output registers, issue_valid=1 next cycle, rep_cnt = cmd_repeat if opcode in {100,101} else 0, go to RUN.
- FSM state RUN:
  - rep_cnt>0: re-drive identical fields with issue_valid=1, decrement rep_cnt.
  - rep_cnt==0 and the next command is available: pop it back-to-back, with no bubble.
  - Otherwise: drive the idle pattern with issue_valid=0 and go to IDLE.
- issue_last=1 on the cycle rep_cnt==0 while issuing.
- Drop handling when DROP_INVALID=1:
  - An invalid head is popped without issue and drop_count increments, saturating at 255.
  - At most one pop per cycle, so a drop consumes that cycle's issue slot and the bus shows the idle pattern.
- When DROP_INVALID=0, invalid commands are issued normally and drop_count stays 0.
- Latency: push at edge e into an empty FIFO in IDLE gives issue_valid high in the cycle after edge e+1.
- result_valid and result_last are issue_valid and issue_last delayed ALSU_LATENCY cycles through a shift register.
- flush:
  - At the next edge: FIFO emptied, rep_cnt=0, FSM IDLE, bus set to the idle pattern.
  - A push in the same cycle is discarded.
  - The result shift register is cleared.
  - drop_count is kept.
- Reset asserted mid-repeat: everything returns to reset values immediately (asynchronous).
- Pointers wrap modulo DEPTH; full/empty are tracked with an occupancy counter of width log2(DEPTH)+1.

Test Plan:
- Reset, then push {A=3,B=1,op=010,cin=1} -> after 2 edges A=3,B=1,opcode=010,issue_valid=1 for one cycle; result_valid 2 cycles later.
- Push {op=100,direction=1,serial_in=1,repeat=3} then {op=000,A=1,B=2} -> 4 consecutive issue_valid cycles of the shift with issue_last on the 4th, then the OR command immediately after, then idle.
- DROP_INVALID=1, push {op=110}, {op=011,red_op_A=1}, {op=001,A=5,B=2} -> only op=001 issued, drop_count=2.
- Hold issue busy with repeat=7 and push 5 commands (DEPTH=4) -> cmd_ready=0 after the 4th accepted; the 5th is held by the source and accepted when the first pop frees a slot.
- Assert flush mid-repeat with 2 queued commands -> next cycle issue_valid=0, bus all zero, cmd_ready=1, and the FIFO is empty (no further issues).
- Assert rst asynchronously during a repeat -> all outputs 0 immediately without waiting for clk, and drop_count=0.
